// File: rtl/multimode_shift_engine_if.sv
// Bus bundle for multimode_shift_engine.
//   master: drives load/start/mode/Right/shift_count/Parallel_in/Serial_in,
//           observes Parallel_Out/Serial_out/busy/done.
//   slave : the shift engine itself (mirror directions).
interface multimode_shift_engine_if #(
    parameter int unsigned WORD_LENGTH = 8,
    parameter int unsigned STEP        = 1,
    parameter int unsigned CNT_WIDTH   = $clog2(WORD_LENGTH + 1)
);

    logic                   load;
    logic                   start;
    logic [1:0]             mode;
    logic                   Right;
    logic [CNT_WIDTH-1:0]   shift_count;
    logic [WORD_LENGTH-1:0] Parallel_in;
    logic [STEP-1:0]        Serial_in;
    logic [WORD_LENGTH-1:0] Parallel_Out;
    logic [STEP-1:0]        Serial_out;
    logic                   busy;
    logic                   done;

    modport master (
        output load, start, mode, Right, shift_count, Parallel_in, Serial_in,
        input  Parallel_Out, Serial_out, busy, done
    );

    modport slave (
        input  load, start, mode, Right, shift_count, Parallel_in, Serial_in,
        output Parallel_Out, Serial_out, busy, done
    );

endinterface

// File: rtl/multimode_shift_engine.sv
// Counter-driven multi-mode shift register.
// Loads a word, then autonomously shifts it STEP bits per cycle for
// shift_count cycles (logical / rotate / arithmetic / serial-fill, either
// direction) with a start / busy / done handshake.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - multimode_shift_engine_if.slave (control, data, status)
module multimode_shift_engine #(
    parameter int unsigned WORD_LENGTH = 8,
    parameter int unsigned STEP        = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    multimode_shift_engine_if.slave  bus
);

    localparam int unsigned CNT_WIDTH = $clog2(WORD_LENGTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MODE_LOGICAL = 2'b00,
        MODE_ROTATE  = 2'b01,
        MODE_ARITH   = 2'b10,
        MODE_SERIAL  = 2'b11
    } mode_e;

    state_e                 state_q, state_d;
    logic [WORD_LENGTH-1:0] reg_q,   reg_d;
    logic [CNT_WIDTH-1:0]   cnt_q,   cnt_d;
    mode_e                  mode_q,  mode_d;
    logic                   right_q, right_d;
    logic                   busy_q;
    logic                   done_q;

    logic [STEP-1:0]        fill;
    logic [WORD_LENGTH-1:0] shifted;

    // Fill bits entering the vacated end for the latched mode/direction.
    always_comb begin
        fill = '0;
        if (right_q) begin
            unique case (mode_q)
                MODE_LOGICAL: fill = '0;
                MODE_ROTATE:  fill = reg_q[STEP-1:0];
                MODE_ARITH:   fill = {STEP{reg_q[WORD_LENGTH-1]}};
                MODE_SERIAL:  fill = bus.Serial_in;
                default:      fill = '0;
            endcase
        end else begin
            unique case (mode_q)
                MODE_LOGICAL: fill = '0;
                MODE_ROTATE:  fill = reg_q[WORD_LENGTH-1 -: STEP];
                MODE_ARITH:   fill = '0;
                MODE_SERIAL:  fill = bus.Serial_in;
                default:      fill = '0;
            endcase
        end
    end

    // One STEP-bit shift of the current register.
    always_comb begin
        if (right_q) begin
            shifted = {fill, reg_q[WORD_LENGTH-1:STEP]};
        end else begin
            shifted = {reg_q[WORD_LENGTH-1-STEP:0], fill};
        end
    end

    // Next-state / datapath decode.
    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        right_d = right_q;

        unique case (state_q)
            ST_SHIFT: begin
                reg_d = shifted;
                cnt_d = cnt_q - CNT_WIDTH'(1);
                if (cnt_q == CNT_WIDTH'(1)) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                // IDLE and DONE accept commands identically; load beats start.
                state_d = ST_IDLE;
                if (bus.load) begin
                    reg_d = bus.Parallel_in;
                end else if (bus.start) begin
                    if (bus.shift_count == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        mode_d  = mode_e'(bus.mode);
                        right_d = bus.Right;
                        cnt_d   = bus.shift_count;
                        state_d = ST_SHIFT;
                    end
                end
            end
        endcase
    end

    // State, datapath and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            reg_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= MODE_LOGICAL;
            right_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            right_q <= right_d;
            busy_q  <= (state_d == ST_SHIFT);
            done_q  <= (state_d == ST_DONE);
        end
    end

    // Serial_out shows the bits leaving on the next shift, only while busy.
    always_comb begin
        bus.Serial_out = '0;
        if (busy_q) begin
            bus.Serial_out = right_q ? reg_q[STEP-1:0] : reg_q[WORD_LENGTH-1 -: STEP];
        end
    end

    assign bus.Parallel_Out = reg_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_multimode_shift_engine.sv
// Self-checking bench for multimode_shift_engine (W=8 with STEP=1 and STEP=2).
module tb_multimode_shift_engine;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    multimode_shift_engine_if #(.WORD_LENGTH(8), .STEP(1)) bus1 ();
    multimode_shift_engine_if #(.WORD_LENGTH(8), .STEP(2)) bus2 ();

    multimode_shift_engine #(.WORD_LENGTH(8), .STEP(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    multimode_shift_engine #(.WORD_LENGTH(8), .STEP(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    typedef struct {
        logic       rst;
        logic       load;
        logic       start;
        logic [1:0] mode;
        logic       right;
        logic [3:0] cnt;
        logic [7:0] pin;
        logic       sin;
        logic [7:0] pout;
        logic       sout;
        logic       busy;
        logic       done;
    } vec_t;

    typedef struct {
        int         idx;
        logic [7:0] pout;
        logic       sout;
        logic       busy;
        logic       done;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s (step %0d): got %0h, required %0h", name, idx, act, req);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic ld, input logic st,
                                input logic [1:0] md, input logic rt, input logic [3:0] c,
                                input logic [7:0] pi, input logic si, input logic [7:0] po,
                                input logic so, input logic b, input logic d);
        vec_t v;
        v.rst = r;   v.load = ld; v.start = st; v.mode = md; v.right = rt;
        v.cnt = c;   v.pin = pi;  v.sin = si;   v.pout = po; v.sout = so;
        v.busy = b;  v.done = d;
        return v;
    endfunction

    task automatic idle1();
        bus1.load = 1'b0; bus1.start = 1'b0; bus1.mode = 2'b00; bus1.Right = 1'b0;
        bus1.shift_count = '0; bus1.Parallel_in = '0; bus1.Serial_in = '0;
    endtask

    // Start a sequence on dut1 and wait (bounded) for done; check busy length and result.
    task automatic run_seq(input string name, input logic [1:0] md, input logic rt,
                           input logic [3:0] c, input logic [7:0] exp_final,
                           input int exp_busy);
        int  nbusy;
        bit  seen;
        nbusy = 0;
        seen  = 1'b0;
        @(negedge clk);
        bus1.start = 1'b1; bus1.mode = md; bus1.Right = rt; bus1.shift_count = c;
        for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
            @(posedge clk);
            #1;
            idle1();
            if (bus1.busy) nbusy++;
            if (bus1.done) seen = 1'b1;
        end
        chk({name, "_done_seen"}, 0, 32'(seen), 32'd1);
        chk({name, "_busy_cycles"}, 0, 32'(nbusy), 32'(exp_busy));
        chk({name, "_final"}, 0, 32'(bus1.Parallel_Out), 32'(exp_final));
        @(posedge clk);
        #1;
        chk({name, "_done_width"}, 0, 32'(bus1.done), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        idle1();
        bus2.load = 1'b0; bus2.start = 1'b0; bus2.mode = 2'b00; bus2.Right = 1'b0;
        bus2.shift_count = '0; bus2.Parallel_in = '0; bus2.Serial_in = '0;

        //            rst ld st md  rt cnt pin    sin  pout  so b  d
        tbl.push_back(mk(1, 0, 0, 2'd0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0)); // reset
        // reset mid-sequence
        tbl.push_back(mk(0, 1, 0, 2'd0, 0, 0, 8'hA5, 0, 8'hA5, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 2'd0, 1, 4, 8'h00, 0, 8'hA5, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 2'd0, 0, 0, 8'h00, 0, 8'h52, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 2'd0, 0, 0, 8'h00, 0, 8'h29, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 2'd0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 2'd0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0));
        // normal sequence after reset: logical left x2
        tbl.push_back(mk(0, 1, 0, 2'd0, 0, 0, 8'h0F, 0, 8'h0F, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 2'd0, 0, 2, 8'h00, 0, 8'h0F, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 2'd0, 0, 0, 8'h00, 0, 8'h1E, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 2'd0, 0, 0, 8'h00, 0, 8'h3C, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 2'd0, 0, 0, 8'h00, 0, 8'h3C, 0, 0, 0));
        // rotate left x3 from 81
        tbl.push_back(mk(0, 1, 0, 2'd0, 0, 0, 8'h81, 0, 8'h81, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 2'd1, 0, 3, 8'h00, 0, 8'h81, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 2'd0, 0, 0, 8'h00, 0, 8'h03, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 2'd0, 0, 0, 8'h00, 0, 8'h06, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 2'd0, 0, 0, 8'h00, 0, 8'h0C, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 2'd0, 0, 0, 8'h00, 0, 8'h0C, 0, 0, 0));
        // serial-fill left x8, bits 1,0,1,1,0,0,1,0
        tbl.push_back(mk(0, 1, 0, 2'd0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 2'd3, 0, 8, 8'h00, 0, 8'h00, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 2'd0, 0, 0, 8'h00, 1, 8'h01, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 2'd0, 0, 0, 8'h00, 0, 8'h02, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 2'd0, 0, 0, 8'h00, 1, 8'h05, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 2'd0, 0, 0, 8'h00, 1, 8'h0B, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 2'd0, 0, 0, 8'h00, 0, 8'h16, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 2'd0, 0, 0, 8'h00, 0, 8'h2C, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 2'd0, 0, 0, 8'h00, 1, 8'h59, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 2'd0, 0, 0, 8'h00, 0, 8'hB2, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 2'd0, 0, 0, 8'h00, 0, 8'hB2, 0, 0, 0));
        // count zero: immediate done, no busy
        tbl.push_back(mk(0, 0, 1, 2'd0, 0, 0, 8'h00, 0, 8'hB2, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 2'd0, 0, 0, 8'h00, 0, 8'hB2, 0, 0, 0));
        // load + start together: load wins
        tbl.push_back(mk(0, 1, 1, 2'd0, 1, 3, 8'h11, 0, 8'h11, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 2'd0, 0, 0, 8'h00, 0, 8'h11, 0, 0, 0));
        // load during busy: ignored
        tbl.push_back(mk(0, 0, 1, 2'd0, 1, 2, 8'h00, 0, 8'h11, 1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 2'd0, 0, 0, 8'hFF, 0, 8'h08, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 2'd0, 0, 0, 8'h00, 0, 8'h04, 0, 0, 1));
        // start during busy ignored, start during DONE accepted
        tbl.push_back(mk(0, 0, 1, 2'd2, 1, 1, 8'h00, 0, 8'h04, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 2'd1, 1, 2, 8'h00, 0, 8'h02, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 2'd1, 1, 2, 8'h00, 0, 8'h02, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 2'd0, 0, 0, 8'h00, 0, 8'h01, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 2'd0, 0, 0, 8'h00, 0, 8'h80, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 2'd0, 0, 0, 8'h00, 0, 8'h80, 0, 0, 0));
        // arithmetic right x3 of a negative value
        tbl.push_back(mk(0, 0, 1, 2'd2, 1, 3, 8'h00, 0, 8'h80, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 2'd0, 0, 0, 8'h00, 0, 8'hC0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 2'd0, 0, 0, 8'h00, 0, 8'hE0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 2'd0, 0, 0, 8'h00, 0, 8'hF0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 2'd0, 0, 0, 8'h00, 0, 8'hF0, 0, 0, 0));

        foreach (tbl[i]) begin
            exp_t e;
            exp_t got;
            @(negedge clk);
            rst              = tbl[i].rst;
            bus1.load        = tbl[i].load;
            bus1.start       = tbl[i].start;
            bus1.mode        = tbl[i].mode;
            bus1.Right       = tbl[i].right;
            bus1.shift_count = tbl[i].cnt;
            bus1.Parallel_in = tbl[i].pin;
            bus1.Serial_in   = tbl[i].sin;
            e.idx  = i;
            e.pout = tbl[i].pout;
            e.sout = tbl[i].sout;
            e.busy = tbl[i].busy;
            e.done = tbl[i].done;
            sb.push_back(e);
            @(posedge clk);
            #1;
            got = sb.pop_front();
            chk("parallel_out", got.idx, 32'(bus1.Parallel_Out), 32'(got.pout));
            chk("serial_out",   got.idx, 32'(bus1.Serial_out),   32'(got.sout));
            chk("busy",         got.idx, 32'(bus1.busy),         32'(got.busy));
            chk("done",         got.idx, 32'(bus1.done),         32'(got.done));
        end
        rst = 1'b0;
        idle1();

        // over-long counts: rotate wraps mod 8, logical clears completely
        run_seq("rot_left_10", 2'd1, 1'b0, 4'd10, 8'hC3, 10);
        run_seq("log_right_10", 2'd0, 1'b1, 4'd10, 8'h00, 10);

        // STEP=2 arithmetic right x2 from 90
        @(negedge clk);
        bus2.load = 1'b1; bus2.Parallel_in = 8'h90;
        @(posedge clk); #1;
        bus2.load = 1'b0;
        chk("s2_load", 0, 32'(bus2.Parallel_Out), 32'h90);
        @(negedge clk);
        bus2.start = 1'b1; bus2.mode = 2'b10; bus2.Right = 1'b1; bus2.shift_count = 4'd2;
        @(posedge clk); #1;
        bus2.start = 1'b0;
        chk("s2_busy0",  0, 32'(bus2.busy),         32'd1);
        chk("s2_pout0",  0, 32'(bus2.Parallel_Out), 32'h90);
        @(posedge clk); #1;
        chk("s2_pout1",  1, 32'(bus2.Parallel_Out), 32'hE4);
        chk("s2_busy1",  1, 32'(bus2.busy),         32'd1);
        @(posedge clk); #1;
        chk("s2_pout2",  2, 32'(bus2.Parallel_Out), 32'hF9);
        chk("s2_done2",  2, 32'(bus2.done),         32'd1);
        chk("s2_busy2",  2, 32'(bus2.busy),         32'd0);
        @(posedge clk); #1;
        chk("s2_done3",  3, 32'(bus2.done),         32'd0);
        chk("s2_pout3",  3, 32'(bus2.Parallel_Out), 32'hF9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multimode_shift_engine.md
Name: multimode_shift_engine

Overview:
Parametrised, counter-driven successor to the team's basic load/shift register. It loads a word, then runs an autonomous multi-cycle shift sequence of programmable length with start/busy/done handshake. Supported modes are logical, rotate, arithmetic and serial-fill, in both directions, shifting STEP bits per cycle. It sits between datapath registers and serial links or ALU shift paths that previously needed an external controller to pulse shift N times.

Parameters:
WORD_LENGTH  8  register width in bits; must be >= 2.
STEP  1  bits moved per shift cycle; 1 <= STEP < WORD_LENGTH.
CNT_WIDTH  $clog2(WORD_LENGTH+1)  width of shift_count and the internal down-counter (derived; do not override).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous reset, active-high.
load  input  1  capture Parallel_in; honoured only when not busy.
start  input  1  begin a shift sequence; honoured only when not busy.
mode  input  2  00 logical, 01 rotate, 10 arithmetic, 11 serial-fill; sampled on start.
Right  input  1  1 = shift toward LSB, 0 = toward MSB; sampled on start.
shift_count  input  CNT_WIDTH  number of STEP-bit shift cycles to run; sampled on start.
Parallel_in  input  WORD_LENGTH  load data.
Serial_in  input  STEP  fill bits for mode 11; sampled every shifting cycle.
Parallel_Out  output  WORD_LENGTH  register contents.
Serial_out  output  STEP  bits being shifted out this cycle.
busy  output  1  sequence in progress.
done  output  1  one-cycle completion pulse.

Behaviour:
- Reset: rst high at a clk edge clears all of the following: state to IDLE, register 0, counter 0, latched mode/Right 0, busy 0, done 0, Serial_out 0. Reset overrides every other input, including mid-sequence; the aborted sequence produces no done pulse.
- States: IDLE, SHIFT, DONE. busy = (state == SHIFT). done = (state == DONE).
- IDLE/DONE, priority order:
  - load=1: register <= Parallel_in. Any start in the same cycle is ignored.
  - start=1 with shift_count=0: go to DONE; register is unchanged.
  - start=1 with shift_count>0: latch mode, Right and count; go to SHIFT.
  - Otherwise: go to IDLE.
  - DONE lasts exactly one cycle. It accepts load/start exactly like IDLE, so back-to-back sequences are allowed.
- SHIFT:
  - Every cycle shifts the register by STEP and decrements the counter.
  - When the counter is 1 at the edge, the final shift occurs and the state moves to DONE.
  - load, start, mode, Right and shift_count are ignored while busy.
- Latency: with start accepted at edge k and N = shift_count, shifts occur at edges k+1 .. k+N. done is high for the cycle after edge k+N. busy is high from edge k to edge k+N.
- Fill rules, left shift (Right=0): register <= {reg[W-1-STEP:0], fill}.
  - Logical and arithmetic: fill = 0.
  - Rotate: fill = reg[W-1:W-STEP].
  - Serial-fill: fill = Serial_in.
- Fill rules, right shift (Right=1): register <= {fill, reg[W-1:STEP]}.
  - Logical: fill = 0.
  - Arithmetic: fill = STEP copies of reg[W-1].
  - Rotate: fill = reg[STEP-1:0].
  - Serial-fill: fill = Serial_in.
- Serial_out is combinational from the current register while busy; it is 0 otherwise.
  - Left shift: reg[W-1:W-STEP].
  - Right shift: reg[STEP-1:0].
- shift_count * STEP may exceed WORD_LENGTH. Shifting continues for the full count, so logical mode clears fully and rotate wraps modulo WORD_LENGTH.
- Parallel_Out is the register output directly; there is no extra pipeline stage.

Test Plan:
- W=8, STEP=1: reset mid-sequence. Load 8'hA5, start logical right with count 4, assert rst after 2 shifts. Required: Parallel_Out=0, busy=0, no done pulse; next start behaves normally.
- W=8, STEP=1: load 8'h81, start rotate left with count 3. Required: Parallel_Out goes 8'h03, 8'h06, 8'h0C; Serial_out goes 1, 0, 0; busy high for 3 cycles, then done high for exactly 1 cycle.
- W=8, STEP=2: load 8'h90, start arithmetic right with count 2. Required: 8'hE4, then 8'hF9; done one cycle after the last shift.
- W=8, STEP=1: load 8'h00, start serial-fill left with count 8, Serial_in = 1,0,1,1,0,0,1,0. Required: final Parallel_Out 8'hB2.
- Start with count=0. Required: done pulses the next cycle, busy never rises, register unchanged.
- Contention and back-to-back:
  - Load plus start in the same IDLE cycle: load wins, no sequence starts.
  - Load during busy: ignored.
  - Start during DONE: a new sequence starts immediately, and done is not extended.
